systolic_mm_stream: RTL and testbench
=====================================

// Module: systolic_mm_stream
// PURPOSE
//   Parametrised streaming successor of the fixed 4x4 systolic multiplier: computes
//   C(ROWSxCOLS) = A(ROWSxK) * B(KxCOLS) with runtime K, valid/ready input and output
//   streams, internal input skewing, an accumulate-onto-C mode and a start/busy/done FSM.
//   Sits between the operand buffers and the result writeback in the accelerator datapath.
// PARAMETERS
//   WIDTH     8                          signed operand width
//   ROWS      4                          array rows (rows of A / C)
//   COLS      4                          array columns (cols of B / C)
//   KMAX      16                         max inner dimension per job
//   ACC_WIDTH 2*WIDTH+$clog2(KMAX)       signed accumulator width (no overflow for K<=KMAX)
// PORTS
//   clk        in   1                   clock
//   rst_n      in   1                   asynchronous active-low reset
//   start      in   1                   job start pulse, sampled in IDLE only
//   accumulate in   1                   sampled with start: 1 = add onto held C, 0 = clear C
//   k_len      in   $clog2(KMAX+1)      inner dimension K; values > KMAX clamp to KMAX
//   busy       out  1                   high from accepted start until done
//   done       out  1                   one-cycle pulse after last output row accepted
//   in_valid   in   1                   operand beat valid
//   in_ready   out  1                   high only in LOAD
//   a_col      in   ROWS*WIDTH          column k of A, element i at [i*WIDTH +: WIDTH]
//   b_row      in   COLS*WIDTH          row k of B, element j at [j*WIDTH +: WIDTH]
//   out_valid  out  1                   result row valid (OUT state)
//   out_ready  in   1                   result row accept
//   out_row    out  $clog2(ROWS)        index of row on out_data
//   out_data   out  COLS*ACC_WIDTH      C[out_row][j] at [j*ACC_WIDTH +: ACC_WIDTH]
// BEHAVIOUR
//   Reset: state IDLE; busy, done, in_ready, out_valid, out_row = 0; out_data, all PE
//     accumulators and skew registers = 0. Reset mid-job aborts it completely.
//   FSM IDLE -> LOAD (start=1; K>0) | IDLE -> DRAIN (start=1; K=0, zero shifts)
//       LOAD -> DRAIN after K-th accepted beat; DRAIN -> OUT after ROWS+COLS-1 shift cycles
//       OUT -> IDLE when row ROWS-1 accepted; done=1 that next cycle, busy=0.
//   start: accumulate=0 clears all accumulators same edge; start while busy is ignored.
//   Shift enable = (in_valid & in_ready) | DRAIN. No shift on stall: skew regs and PEs hold.
//   Skew: A element i delayed i shifts, B element j delayed j shifts; zeros injected in DRAIN.
//   PE(i,j) on shift: acc += a_in*b_in (full signed, sign-extended to ACC_WIDTH, two's
//     complement wrap); forwards a right, b down via registers.
//   Output: out_row counts 0..ROWS-1; out_data/out_row held stable while out_valid &
//     !out_ready; row advances on out_valid & out_ready. Accumulators retain C after done.
//   Latency (no stalls): done = K + (ROWS+COLS-1) + ROWS + 1 cycles after start.
// STRUCTURE
//   Package systolic_pkg: state_e {IDLE,LOAD,DRAIN,OUT}, helper functions for ACC_WIDTH
//     and counter widths, shared WIDTH default.
//   Sub-module mac_pe: one PE (a/b forward registers, accumulator, clear, shift enable);
//     top holds FSM, counters, skew shift registers and generate-loop PE grid.
// TESTING
//   1 Identity A x B{1..16 row-major}, K=4, accumulate=0 -> rows {1,2,3,4},{5,6,7,8},
//     {9,10,11,12},{13,14,15,16}; done at cycle 4+7+4+1=16 after start.
//   2 Repeat test 1 with accumulate=1 -> every element doubled (2,4,...,32).
//   3 All operands -128, K=16 -> every C element 262144, no wrap.
//   4 Random in_valid gaps and out_ready low 3 cycles per row -> results equal test 1;
//     out_data/out_row unchanged across each stall.
//   5 K=0, accumulate=0 -> four all-zero rows then done; start pulsed in LOAD ignored.
//   6 rst_n low mid-LOAD (beat 2 of 4) -> all outputs 0 immediately; next job per test 1 exact.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the streaming systolic matrix multiplier.
package systolic_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Accumulator wide enough for KMAX full-precision signed products.
  function automatic int acc_width(input int width, input int kmax);
    return 2 * width + $clog2(kmax);
  endfunction

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mac_pe.sv
// One systolic processing element: forwards a right and b down, accumulates a*b on shift.
module mac_pe #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_en,
  input  logic                        i_clr,
  input  logic signed [WIDTH-1:0]     i_a,
  input  logic signed [WIDTH-1:0]     i_b,
  output logic signed [WIDTH-1:0]     o_a,
  output logic signed [WIDTH-1:0]     o_b,
  output logic signed [ACC_WIDTH-1:0] o_acc
);

  logic signed [2*WIDTH-1:0]   w_prod;
  logic signed [WIDTH-1:0]     r_a;
  logic signed [WIDTH-1:0]     r_b;
  logic signed [ACC_WIDTH-1:0] r_acc;

  assign w_prod = i_a * i_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else begin
      if (i_en) begin
        r_a <= i_a;
        r_b <= i_b;
      end
      // Clear wins over shift; the FSM never asks for both in one cycle.
      if (i_clr) begin
        r_acc <= '0;
      end else if (i_en) begin
        r_acc <= r_acc + {{(ACC_WIDTH-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
      end
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule

// File: rtl/systolic_mm_stream.sv
// Streaming ROWSxCOLS systolic multiplier with runtime K, input skew and row-wise result stream.
module systolic_mm_stream
  import systolic_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int KMAX      = 16,
  parameter int ACC_WIDTH = acc_width(WIDTH, KMAX)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          accumulate,
  input  logic [$clog2(KMAX+1)-1:0]     k_len,
  output logic                          busy,
  output logic                          done,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*WIDTH-1:0]         a_col,
  input  logic [COLS*WIDTH-1:0]         b_row,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(ROWS)-1:0]       out_row,
  output logic [COLS*ACC_WIDTH-1:0]     out_data,
  output state_e                        dbg_state
);

  localparam int KW = $clog2(KMAX + 1);
  localparam int RW = $clog2(ROWS);
  localparam int DW = cnt_width(ROWS + COLS - 2);
  localparam logic [KW-1:0] K_MAX_L    = KW'(KMAX);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(ROWS + COLS - 2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  state_e        r_state, w_next;
  logic [KW-1:0] r_k, r_beat, w_k_clamp;
  logic [DW-1:0] r_drain;
  logic [RW-1:0] r_row;
  logic          r_done, w_start, w_accept, w_shift, w_clr, w_row_acc;

  // Handshakes: a beat/row transfers on the rising edge where valid & ready are both high;
  // the source holds its payload while valid & !ready.
  assign w_k_clamp = (k_len > K_MAX_L) ? K_MAX_L : k_len;
  assign w_start   = (r_state == IDLE) && start;
  assign w_accept  = in_valid && (r_state == LOAD);
  assign w_shift   = w_accept || (r_state == DRAIN);
  assign w_clr     = w_start && !accumulate;
  assign w_row_acc = (r_state == OUT) && out_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (w_k_clamp == '0) ? DRAIN : LOAD;
      LOAD:    if (w_accept && ((r_beat + KW'(1)) == r_k)) w_next = DRAIN;
      DRAIN:   if (r_drain == DRAIN_LAST) w_next = OUT;
      OUT:     if (out_ready && (r_row == ROW_LAST)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_beat  <= '0;
      r_drain <= '0;
      r_row   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_row_acc && (r_row == ROW_LAST);
      if (w_start) begin
        r_k     <= w_k_clamp;
        r_beat  <= '0;
        r_drain <= '0;
        r_row   <= '0;
      end
      if (w_accept) r_beat <= r_beat + KW'(1);
      if (r_state == DRAIN) r_drain <= r_drain + DW'(1);
      if (w_row_acc) r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
    end
  end

  logic signed [WIDTH-1:0]     w_a   [ROWS][COLS+1];
  logic signed [WIDTH-1:0]     w_b   [ROWS+1][COLS];
  logic signed [ACC_WIDTH-1:0] w_acc [ROWS][COLS];
  logic [ROWS-1:0]             w_unused_a;
  logic [COLS-1:0]             w_unused_b;

  // Row i of A is delayed i shifts so diagonals meet in the right PE; DRAIN injects zeros.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_skew
    logic signed [WIDTH-1:0] w_in;
    assign w_in = (r_state == DRAIN) ? '0 : a_col[gi*WIDTH +: WIDTH];
    assign w_unused_a[gi] = ^w_a[gi][COLS];
    if (gi == 0) begin : g_direct
      assign w_a[gi][0] = w_in;
    end else begin : g_delay
      logic signed [WIDTH-1:0] r_sr [gi];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < gi; d++) r_sr[d] <= '0;
        end else if (w_shift) begin
          r_sr[0] <= w_in;
          for (int d = 1; d < gi; d++) r_sr[d] <= r_sr[d-1];
        end
      end
      assign w_a[gi][0] = r_sr[gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_b_skew
    logic signed [WIDTH-1:0] w_in;
    assign w_in = (r_state == DRAIN) ? '0 : b_row[gj*WIDTH +: WIDTH];
    assign w_unused_b[gj] = ^w_b[ROWS][gj];
    if (gj == 0) begin : g_direct
      assign w_b[0][gj] = w_in;
    end else begin : g_delay
      logic signed [WIDTH-1:0] r_sr [gj];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < gj; d++) r_sr[d] <= '0;
        end else if (w_shift) begin
          r_sr[0] <= w_in;
          for (int d = 1; d < gj; d++) r_sr[d] <= r_sr[d-1];
        end
      end
      assign w_b[0][gj] = r_sr[gj-1];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      mac_pe #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_shift),
        .i_clr (w_clr),
        .i_a   (w_a[gi][gj]),
        .i_b   (w_b[gi][gj]),
        .o_a   (w_a[gi][gj+1]),
        .o_b   (w_b[gi+1][gj]),
        .o_acc (w_acc[gi][gj])
      );
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < COLS; j++) out_data[j*ACC_WIDTH +: ACC_WIDTH] = w_acc[r_row][j];
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign in_ready  = (r_state == LOAD);
  assign out_valid = (r_state == OUT);
  assign out_row   = r_row;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_systolic_mm_stream.sv
// Self-checking bench for systolic_mm_stream: vector table of jobs plus a reset-abort sequence.
module tb_systolic_mm_stream;

  localparam int WIDTH = 8;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KMAX  = 16;
  localparam int ACCW  = 2 * WIDTH + $clog2(KMAX);
  localparam int KW    = $clog2(KMAX + 1);
  localparam int RW    = $clog2(ROWS);
  localparam int DWD   = COLS * ACCW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0, accumulate = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [KW-1:0]     k_len = '0;
  logic [ROWS*WIDTH-1:0] a_col = '0;
  logic [COLS*WIDTH-1:0] b_row = '0;
  logic              busy, done, in_ready, out_valid;
  logic [RW-1:0]     out_row;
  logic [DWD-1:0]    out_data;
  logic [1:0]        dbg_state;

  systolic_mm_stream #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS), .KMAX(KMAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .accumulate(accumulate), .k_len(k_len),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_data(out_data), .dbg_state(dbg_state)
  );

  typedef struct {
    string name;
    int    k;
    bit    acc;
    int    pat;      // 0 identity x 1..16, 1 all -128, 2 random, 3 zeros
    bit    gaps;
    bit    stalls;
    bit    spur;     // pulse start while in LOAD
    int    exp_lat;  // start-to-done cycles, 0 = not checked
  } vec_t;

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [DWD-1:0] exp_q[$];
  longint model_c [ROWS][COLS];
  int a_mat [ROWS][KMAX];
  int b_mat [KMAX][COLS];
  vec_t vecs [10];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input int k, input bit acc, input int pat,
                              input bit gaps, input bit stalls, input bit spur, input int lat);
    vec_t v;
    v.name = name; v.k = k; v.acc = acc; v.pat = pat;
    v.gaps = gaps; v.stalls = stalls; v.spur = spur; v.exp_lat = lat;
    return v;
  endfunction

  task automatic fill_operands(input int pat);
    for (int k = 0; k < KMAX; k++) begin
      for (int i = 0; i < ROWS; i++)
        a_mat[i][k] = (pat == 0) ? ((i == k) ? 1 : 0) :
                      (pat == 1) ? -128 : (pat == 2) ? int'($urandom_range(0, 255)) - 128 : 0;
      for (int j = 0; j < COLS; j++)
        b_mat[k][j] = (pat == 0) ? ((k < 4) ? k * COLS + j + 1 : 0) :
                      (pat == 1) ? -128 : (pat == 2) ? int'($urandom_range(0, 255)) - 128 : 0;
    end
  endtask

  // Reference: C = (acc ? C : 0) + A*B over the first k_eff inner terms, rows queued in order.
  task automatic model_job(input int k_eff, input bit acc);
    logic [DWD-1:0] row;
    longint v;
    for (int r = 0; r < ROWS; r++) begin
      row = '0;
      for (int j = 0; j < COLS; j++) begin
        if (!acc) model_c[r][j] = 0;
        for (int k = 0; k < k_eff; k++) model_c[r][j] += longint'(a_mat[r][k]) * b_mat[k][j];
        v = model_c[r][j];
        row[j*ACCW +: ACCW] = v[ACCW-1:0];
      end
      exp_q.push_back(row);
    end
  endtask

  task automatic drive_beat(input int beat);
    for (int i = 0; i < ROWS; i++) a_col[i*WIDTH +: WIDTH] = WIDTH'(a_mat[i][beat]);
    for (int j = 0; j < COLS; j++) b_row[j*WIDTH +: WIDTH] = WIDTH'(b_mat[beat][j]);
  endtask

  task automatic run_job(input vec_t v);
    int k_eff;
    int n;
    int beat;
    int guard;
    bit acc_now;
    logic [DWD-1:0] exp_row;
    k_eff = (v.k > KMAX) ? KMAX : v.k;
    fill_operands(v.pat);
    model_job(k_eff, v.acc);
    start = 1'b1; accumulate = v.acc; k_len = KW'(v.k);
    tick; n = 1;
    start = 1'b0; accumulate = 1'b0;
    chk({v.name, ":busy_after_start"}, busy, 1);
    chk({v.name, ":in_ready_after_start"}, in_ready, (k_eff > 0));
    beat = 0; guard = 0;
    while (beat < k_eff && guard < 400) begin
      in_valid = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      drive_beat(beat);
      if (v.spur && beat == 2) start = 1'b1;
      acc_now = in_valid && in_ready;
      tick; n++; guard++;
      start = 1'b0;
      if (acc_now) beat++;
    end
    in_valid = 1'b0;
    chk({v.name, ":beats_accepted"}, beat, k_eff);
    for (int r = 0; r < ROWS; r++) begin
      guard = 0;
      while (!out_valid && guard < 50) begin tick; n++; guard++; end
      chk({v.name, ":out_valid"}, out_valid, 1);
      exp_row = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk($sformatf("%s:out_row%0d", v.name, r), out_row, r);
      chk($sformatf("%s:out_data%0d", v.name, r), out_data, exp_row);
      if (v.stalls) begin
        for (int s = 0; s < 3; s++) begin
          tick; n++;
          chk($sformatf("%s:stall_row%0d", v.name, r), out_row, r);
          chk($sformatf("%s:stall_data%0d", v.name, r), out_data, exp_row);
        end
      end
      out_ready = 1'b1;
      tick; n++;
      out_ready = 1'b0;
    end
    chk({v.name, ":done"}, done, 1);
    chk({v.name, ":busy_at_done"}, busy, 0);
    if (v.exp_lat > 0) chk({v.name, ":latency"}, n, v.exp_lat);
    tick;
    chk({v.name, ":done_pulse"}, done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DWD-1:0] e;
    vecs[0] = mk("ident",       4, 1'b0, 0, 1'b0, 1'b0, 1'b0, 16);
    vecs[1] = mk("ident_acc",   4, 1'b1, 0, 1'b0, 1'b0, 1'b0, 16);
    vecs[2] = mk("neg_max",    16, 1'b0, 1, 1'b0, 1'b0, 1'b0, 28);
    vecs[3] = mk("ident_stall", 4, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
    vecs[4] = mk("k_zero",      0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 12);
    vecs[5] = mk("spur_start",  4, 1'b0, 0, 1'b0, 1'b0, 1'b1, 16);
    vecs[6] = mk("rand_k7",     7, 1'b0, 2, 1'b1, 1'b1, 1'b0, 0);
    vecs[7] = mk("rand_acc",    5, 1'b1, 2, 1'b0, 1'b0, 1'b0, 17);
    vecs[8] = mk("clamp_k20",  20, 1'b0, 2, 1'b0, 1'b0, 1'b0, 28);
    vecs[9] = mk("rand_k16",   16, 1'b1, 2, 1'b1, 1'b1, 1'b0, 0);

    repeat (3) tick;
    chk("reset:busy", busy, 0);
    chk("reset:done", done, 0);
    chk("reset:in_ready", in_ready, 0);
    chk("reset:out_valid", out_valid, 0);
    chk("reset:out_row", out_row, 0);
    chk("reset:out_data", out_data, 0);
    chk("reset:state", dbg_state, 0);
    rst_n = 1'b1;
    tick;

    for (int t = 0; t < 10; t++) run_job(vecs[t]);

    // Abort mid-LOAD: two of four beats in, then asynchronous reset.
    fill_operands(0);
    start = 1'b1; k_len = KW'(4);
    tick;
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      drive_beat(b);
      tick;
    end
    e = '0;
    e[0 +: ACCW]    = ACCW'(1);
    e[ACCW +: ACCW] = ACCW'(2);
    chk("abort:row0_partial", out_data, e);
    drive_beat(2);
    rst_n = 1'b0;
    #1;
    chk("abort:busy", busy, 0);
    chk("abort:in_ready", in_ready, 0);
    chk("abort:out_valid", out_valid, 0);
    chk("abort:done", done, 0);
    chk("abort:out_row", out_row, 0);
    chk("abort:out_data", out_data, 0);
    in_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    run_job(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
